// File: rtl/grid_loader_pkg.sv
// grid_loader_pkg: default grid geometry, ASCII codes and state encodings shared by the loader and its write port
package grid_loader_pkg;
  localparam int DEFAULT_TX_DATA_WIDTH = 8;
  localparam int DEFAULT_MAX_COLS = 16;
  localparam int DEFAULT_BANK_DEPTH = 4;
  localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_BANK_DEPTH + 1);
  localparam int DEFAULT_COL_W = $clog2(DEFAULT_MAX_COLS + 1);
  localparam logic [7:0] NEWLINE = 8'd10;
  localparam logic [7:0] ROLL = 8'h40;
  typedef logic [1:0] state_t;
  localparam state_t L_ACCEPT = 2'd0;
  localparam state_t L_FLUSH = 2'd1;
  localparam state_t L_DONE = 2'd2;
  localparam state_t P_IDLE = 2'd0;
  localparam state_t P_WRITE = 2'd1;
  localparam state_t P_DRAIN = 2'd2;
endpackage

// File: rtl/grid_loader_if.sv
// grid_loader_if: byte stream, memory write port and status of the grid loader; GRID_LOADER_STATS_EN adds the stats outputs
interface grid_loader_if
  import grid_loader_pkg::*;
#(
  parameter int W = DEFAULT_TX_DATA_WIDTH,
  parameter int AW = DEFAULT_ADDR_W,
  parameter int CW = DEFAULT_COL_W
);
  logic char_valid_in, eof_in, char_ready_out;
  logic [7:0] char_in;
  logic write_en_out, ack_in, busy_in, overflow_out, done_out;
  logic [AW-1:0] row_addr_out, rows_out;
  logic [CW-1:0] col_addr_out;
  logic [W-1:0] partial_vec_out;
`ifdef GRID_LOADER_STATS_EN
  logic [31:0] roll_count_out;
  logic [CW-1:0] max_cols_out;
  modport master (
    input char_valid_in, char_in, eof_in, ack_in, busy_in,
    output char_ready_out, write_en_out, row_addr_out, col_addr_out, partial_vec_out,
    output rows_out, overflow_out, done_out, roll_count_out, max_cols_out
  );
  modport slave (
    output char_valid_in, char_in, eof_in, ack_in, busy_in,
    input char_ready_out, write_en_out, row_addr_out, col_addr_out, partial_vec_out,
    input rows_out, overflow_out, done_out, roll_count_out, max_cols_out
  );
`else
  modport master (
    input char_valid_in, char_in, eof_in, ack_in, busy_in,
    output char_ready_out, write_en_out, row_addr_out, col_addr_out, partial_vec_out,
    output rows_out, overflow_out, done_out
  );
  modport slave (
    output char_valid_in, char_in, eof_in, ack_in, busy_in,
    input char_ready_out, write_en_out, row_addr_out, col_addr_out, partial_vec_out,
    input rows_out, overflow_out, done_out
  );
`endif
endinterface

// File: rtl/grid_loader_mem_write_port.sv
// mem_write_port: one memory write per start; holds address/data in WRITE until ack, then DRAINs until busy clears
module mem_write_port
  import grid_loader_pkg::*;
#(
  parameter int AW = DEFAULT_ADDR_W,
  parameter int CW = DEFAULT_COL_W,
  parameter int W = DEFAULT_TX_DATA_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic [AW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic [W-1:0] data,
  input  logic ack,
  input  logic busy,
  output logic idle,
  output logic write_en,
  output logic [AW-1:0] row_q,
  output logic [CW-1:0] col_q,
  output logic [W-1:0] data_q
);
  state_t st;
  assign idle = st == P_IDLE;
  assign write_en = st == P_WRITE;
  always_ff @(posedge clock)
    if (reset) begin
      st <= P_IDLE;
      row_q <= '0;
      col_q <= '0;
      data_q <= '0;
    end else begin
      st <= idle ? (start ? P_WRITE : P_IDLE) : write_en ? (ack ? P_DRAIN : P_WRITE) : (busy ? P_DRAIN : P_IDLE);
      if (idle && start) begin
        row_q <= row;
        col_q <= col;
        data_q <= data;
      end
    end
endmodule

// File: rtl/grid_loader.sv
// grid_loader: packs '@' occupancy of each row into TX_DATA_WIDTH-bit chunks (power of two, >= 2) and writes them to mem
// GRID_LOADER_STATS_EN adds roll_count_out / max_cols_out
module grid_loader
  import grid_loader_pkg::*;
#(
  parameter int TX_DATA_WIDTH = DEFAULT_TX_DATA_WIDTH,
  parameter int MAX_COLS = DEFAULT_MAX_COLS,
  parameter int BANK_DEPTH = DEFAULT_BANK_DEPTH
) (
  input logic clock,
  input logic reset,
  grid_loader_if.master bus
);
  localparam int AW = $clog2(BANK_DEPTH + 1);
  localparam int CW = $clog2(MAX_COLS + 1);
  localparam int BW = $clog2(TX_DATA_WIDTH);
  state_t ls, ls_nxt;
  logic tgt_done, adv, pending, overflow, idle;
  logic fire, eof, nl, chr, full_row, keep, is_roll, start, acked, advance;
  logic [AW-1:0] row;
  logic [CW-1:0] col;
  logic [TX_DATA_WIDTH-1:0] chunk, nxt;
  assign fire = bus.char_valid_in && ls == L_ACCEPT;
  assign eof = fire && bus.eof_in;
  assign nl = fire && !bus.eof_in && bus.char_in == NEWLINE;
  assign chr = fire && !bus.eof_in && bus.char_in != NEWLINE;
  assign full_row = row >= AW'(BANK_DEPTH);
  assign keep = chr && !full_row && col != CW'(MAX_COLS);
  assign is_roll = bus.char_in == ROLL;
  // eager flush: the byte that fills a chunk launches its write, so no beat is ever held back
  assign start = (keep && &col[BW-1:0]) || ((eof || nl) && pending);
  assign acked = bus.write_en_out && bus.ack_in;
  assign advance = (acked && adv) || (nl && !pending);
  assign ls_nxt = ls == L_ACCEPT ? (eof && !pending ? L_DONE : start ? L_FLUSH : L_ACCEPT) :
                  ls == L_FLUSH ? (idle ? (tgt_done ? L_DONE : L_ACCEPT) : L_FLUSH) : L_DONE;
  assign bus.char_ready_out = ls == L_ACCEPT;
  assign bus.rows_out = row;
  assign bus.overflow_out = overflow;
  assign bus.done_out = ls == L_DONE;
  always_comb begin
    nxt = chunk;
    nxt[col[BW-1:0]] = is_roll;
  end
  always_ff @(posedge clock)
    if (reset) begin
      ls <= L_ACCEPT;
      tgt_done <= 1'b0;
      adv <= 1'b0;
      pending <= 1'b0;
      overflow <= 1'b0;
      row <= '0;
      col <= '0;
      chunk <= '0;
    end else begin
      ls <= ls_nxt;
      if (start) begin
        tgt_done <= eof;
        adv <= nl;
      end
      chunk <= acked ? '0 : keep ? nxt : chunk;
      pending <= acked ? 1'b0 : keep ? 1'b1 : pending;
      col <= advance ? '0 : keep ? col + 1'b1 : col;
      if (advance && !full_row) row <= row + 1'b1;
      overflow <= overflow || (chr && (full_row || col == CW'(MAX_COLS))) || (nl && full_row);
    end
  mem_write_port #(.AW(AW), .CW(CW), .W(TX_DATA_WIDTH)) port (
    .clock,
    .reset,
    .start,
    .row,
    .col({col[CW-1:BW], BW'(0)}),
    .data(keep ? nxt : chunk),
    .ack(bus.ack_in),
    .busy(bus.busy_in),
    .idle,
    .write_en(bus.write_en_out),
    .row_q(bus.row_addr_out),
    .col_q(bus.col_addr_out),
    .data_q(bus.partial_vec_out)
  );
`ifdef GRID_LOADER_STATS_EN
  always_ff @(posedge clock)
    if (reset) begin
      bus.roll_count_out <= '0;
      bus.max_cols_out <= '0;
    end else if (keep) begin
      bus.roll_count_out <= bus.roll_count_out + 32'(is_roll);
      if (col + 1'b1 > bus.max_cols_out) bus.max_cols_out <= col + 1'b1;
    end
`endif
endmodule

// File: tb/tb_grid_loader.sv
// tb_grid_loader: directed byte streams against a line-splitting model of the expected chunk writes
module tb_grid_loader;
  localparam int W = 8;
  localparam int MAXC = 16;
  localparam int DEPTH = 4;
  typedef struct {int row; int col; int data;} wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, failures = 0, busy_len = 0, exp_rows = 0, wcnt = 0, bcnt = 0;
  bit exp_ovf = 1'b0, fl = 1'b0;
  wr_t exp_q[$], act_q[$];
  wr_t a, e;
  always #5 clk = ~clk;
  grid_loader_if bus ();
  grid_loader dut (.clock(clk), .reset(reset), .bus(bus));

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // memory: ack on the second WRITE cycle, then busy for busy_len cycles
  always @(posedge clk) begin
    #2;
    if (reset) begin
      bus.ack_in = 1'b0;
      wcnt = 0;
      bcnt = 0;
    end else if (bus.ack_in) begin
      bus.ack_in = 1'b0;
      bcnt = busy_len;
    end else if (bus.write_en_out) begin
      wcnt++;
      if (wcnt == 2) begin
        bus.ack_in = 1'b1;
        wcnt = 0;
      end
    end else wcnt = 0;
    bus.busy_in = bcnt > 0;
    if (bcnt > 0) bcnt--;
  end

  always @(negedge clk) begin
    if (reset) fl = 1'b0;
    else begin
      if (bus.write_en_out) fl = 1'b1;
      if (fl) chk("ready_low_in_flush", int'(bus.char_ready_out), 0);
      if (!bus.write_en_out && !bus.busy_in) fl = 1'b0;
      if (bus.done_out) chk("done_after_commit", exp_q.size() + int'(bus.write_en_out), 0);
      if (bus.write_en_out && bus.ack_in) begin
        a.row = int'(bus.row_addr_out);
        a.col = int'(bus.col_addr_out);
        a.data = int'(bus.partial_vec_out);
        act_q.push_back(a);
        chk("write_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("write_row", a.row, e.row);
          chk("write_col", a.col, e.col);
          chk("write_data", a.data, e.data);
        end
      end
    end
  end

  // expected writes: every row below DEPTH, truncated to MAXC, split into W-wide chunks
  function automatic void build(string s);
    int r = 0, st = 0;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i <= s.len(); i++)
      if (i == s.len() || s[i] == 8'd10) begin
        int n = i - st;
        bit term = i < s.len();
        if (r >= DEPTH) begin
          if (n > 0 || term) exp_ovf = 1'b1;
        end else begin
          if (n > MAXC) begin
            exp_ovf = 1'b1;
            n = MAXC;
          end
          for (int b = 0; b < n; b += W) begin
            int d = 0;
            for (int j = 0; j < W && b + j < n; j++) if (s[st+b+j] == "@") d |= 1 << j;
            exp_q.push_back('{r, b, d});
          end
        end
        if (term) r++;
        st = i + 1;
      end
    exp_rows = r > DEPTH ? DEPTH : r;
  endfunction

  task automatic do_reset();
    bus.char_valid_in = 1'b0;
    bus.eof_in = 1'b0;
    bus.char_in = 8'h00;
    reset = 1'b1;
    exp_q.delete();
    act_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write_en", int'(bus.write_en_out), 0);
    chk("rst_rows", int'(bus.rows_out), 0);
    chk("rst_overflow", int'(bus.overflow_out), 0);
    chk("rst_done", int'(bus.done_out), 0);
    chk("rst_addr", int'(bus.row_addr_out) + int'(bus.col_addr_out), 0);
    chk("rst_data", int'(bus.partial_vec_out), 0);
    reset = 1'b0;
  endtask

  task automatic send(logic [7:0] c, logic eof);
    int n = 0;
    bus.char_valid_in = 1'b1;
    bus.char_in = c;
    bus.eof_in = eof;
    @(negedge clk);
    while (!bus.char_ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", int'(bus.char_ready_out), 1);
    @(posedge clk);
    #1;
    bus.char_valid_in = 1'b0;
    bus.eof_in = 1'b0;
  endtask

  task automatic run(string name, string s, int bl);
    int n = 0;
    busy_len = bl;
    do_reset();
    build(s);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
    send(8'h00, 1'b1);
    while (!bus.done_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, int'(bus.done_out), 1);
    chk({name, "_writes_left"}, exp_q.size(), 0);
    chk({name, "_rows"}, int'(bus.rows_out), exp_rows);
    chk({name, "_overflow"}, int'(bus.overflow_out), int'(exp_ovf));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    string s20;
    int n;
    run("t1", "@.@@@...@\n", 0);
    chk("t1_nwrites", act_q.size(), 2);
    chk("t1_rows_lit", int'(bus.rows_out), 1);
    if (act_q.size() == 2) begin
      chk("t1_w0_data", act_q[0].data, 'h1D);
      chk("t1_w1_col", act_q[1].col, 8);
      chk("t1_w1_data", act_q[1].data, 'h01);
    end
`ifdef GRID_LOADER_STATS_EN
    chk("t1_roll_count", int'(bus.roll_count_out), 5);
    chk("t1_max_cols", int'(bus.max_cols_out), 9);
`endif
    run("t2", "@@@@@@@@\n", 0);
    chk("t2_nwrites", act_q.size(), 1);
    if (act_q.size() == 1) chk("t2_w0_data", act_q[0].data, 'hFF);
    run("t3", "..@\n@..\n.@.\n", 0);
    chk("t3_nwrites", act_q.size(), 3);
    if (act_q.size() == 3) begin
      chk("t3_w0_data", act_q[0].data, 'h04);
      chk("t3_w2_row", act_q[2].row, 2);
      chk("t3_w2_data", act_q[2].data, 'h02);
    end
    repeat (10) @(negedge clk);
    chk("t3_no_more_writes", act_q.size(), 3);
    s20 = "";
    for (int i = 0; i < 20; i++) s20 = {s20, "@"};
    run("t4", {s20, "\n"}, 0);
    chk("t4_overflow_lit", int'(bus.overflow_out), 1);
    chk("t4_nwrites", act_q.size(), 2);
    if (act_q.size() == 2) chk("t4_w1_col", act_q[1].col, 8);
    run("t5", "@@", 5);
    chk("t5_nwrites", act_q.size(), 1);
    if (act_q.size() == 1) chk("t5_w0_data", act_q[0].data, 'h03);
    busy_len = 0;
    do_reset();
    for (int i = 0; i < 8; i++) send("@", 1'b0);
    n = 0;
    @(negedge clk);
    while (!bus.write_en_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_write_started", int'(bus.write_en_out), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_write_dropped", int'(bus.write_en_out), 0);
    chk("t6_rows", int'(bus.rows_out), 0);
    chk("t6_done", int'(bus.done_out), 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    run("t6r", "@\n", 0);
    chk("t6r_nwrites", act_q.size(), 1);
    if (act_q.size() == 1) chk("t6r_w0_data", act_q[0].data, 'h01);
    run("t7", "@\n@\n@\n@\n@\n", 0);
    chk("t7_rows_lit", int'(bus.rows_out), 4);
    chk("t7_overflow_lit", int'(bus.overflow_out), 1);
    chk("t7_nwrites", act_q.size(), 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
